// File: rtl/mc_decade_counter.sv
// Single-clock digit-counter chain with limited MSD, sticky overrange,
// display latch and one-hot multiplexed digit scan-out.
module mc_decade_counter #(
    parameter int DIGITS   = 4,
    parameter int MODE     = 0,
    parameter int MSD_MAX  = 1,
    parameter int SCAN_DIV = 4
) (
    input  logic                  cp,
    input  logic                  r,
    input  logic                  en,
    input  logic                  clr,
    input  logic                  latch,
    output logic [4*DIGITS-1:0]   cnt,
    output logic [4*DIGITS-1:0]   q,
    output logic                  ovr,
    output logic                  carry,
    output logic [DIGITS-1:0]     ds,
    output logic [3:0]            dq
);

    localparam int              W        = 4 * DIGITS;
    localparam int              DIV_W    = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam logic [3:0]      DIG_MAX  = (MODE != 0) ? 4'd15 : 4'd9;
    localparam logic [3:0]      MSD_LIM  = 4'(MSD_MAX);
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(SCAN_DIV - 1);
    localparam logic [DIGITS-1:0] DS_MSD = {1'b1, {(DIGITS-1){1'b0}}};

    logic [W-1:0]       cnt_q, cnt_d, q_q, q_d, inc_cnt;
    logic               ovr_q, ovr_d, carry_q, carry_d;
    logic [DIGITS-1:0]  ds_q, ds_d;
    logic [DIV_W-1:0]   div_q, div_d;
    logic               ripple, wrap, div_term;
    logic [3:0]         dig, lim;

    // Ripple-carry increment: a digit rolls only while every lower digit rolled.
    always_comb begin
        inc_cnt = '0;
        ripple  = 1'b1;
        dig     = '0;
        lim     = '0;
        for (int k = 0; k < DIGITS; k++) begin
            dig = cnt_q[4*k +: 4];
            lim = (k == DIGITS-1) ? MSD_LIM : DIG_MAX;
            if (!ripple) begin
                inc_cnt[4*k +: 4] = dig;
            end else if (dig == lim) begin
                inc_cnt[4*k +: 4] = 4'd0;
            end else begin
                inc_cnt[4*k +: 4] = dig + 4'd1;
                ripple            = 1'b0;
            end
        end
        wrap = ripple;
    end

    always_comb begin
        cnt_d   = cnt_q;
        ovr_d   = ovr_q;
        carry_d = 1'b0;
        if (clr) begin
            cnt_d = '0;
            ovr_d = 1'b0;
        end else if (en) begin
            cnt_d = inc_cnt;
            if (wrap) begin
                ovr_d   = 1'b1;
                carry_d = 1'b1;
            end
        end
        q_d = latch ? cnt_q : q_q;
    end

    // Scan rotates toward the LSD, wrapping back to the MSD.
    always_comb begin
        div_term = (div_q == DIV_LAST);
        div_d    = div_term ? '0 : div_q + 1'b1;
        ds_d     = ds_q;
        if (div_term) begin
            if (DIGITS > 1) ds_d = {ds_q[0], ds_q[DIGITS-1:1]};
        end
    end

    always_ff @(posedge cp) begin
        if (r) begin
            cnt_q   <= '0;
            q_q     <= '0;
            ovr_q   <= 1'b0;
            carry_q <= 1'b0;
            ds_q    <= DS_MSD;
            div_q   <= '0;
        end else begin
            cnt_q   <= cnt_d;
            q_q     <= q_d;
            ovr_q   <= ovr_d;
            carry_q <= carry_d;
            ds_q    <= ds_d;
            div_q   <= div_d;
        end
    end

    always_comb begin
        dq = '0;
        for (int k = 0; k < DIGITS; k++) begin
            if (ds_q[k]) dq = q_q[4*k +: 4];
        end
    end

    assign cnt   = cnt_q;
    assign q     = q_q;
    assign ovr   = ovr_q;
    assign carry = carry_q;
    assign ds    = ds_q;

endmodule

// File: tb/tb_mc_decade_counter.sv
// Directed table plus hand sequences for the BCD 4-digit chain and a
// 2-digit binary chain.
module tb_mc_decade_counter;

    logic        cp, r;
    logic        a_en, a_clr, a_latch;
    logic [15:0] a_cnt, a_q;
    logic        a_ovr, a_carry;
    logic [3:0]  a_ds, a_dq;

    logic        b_en, b_clr, b_latch;
    logic [7:0]  b_cnt, b_q;
    logic        b_ovr, b_carry;
    logic [1:0]  b_ds;
    logic [3:0]  b_dq;

    int tests = 0;
    int fails = 0;
    logic a_carry_seen, b_carry_seen;

    mc_decade_counter #(.DIGITS(4), .MODE(0), .MSD_MAX(1), .SCAN_DIV(4)) dut_a (
        .cp(cp), .r(r), .en(a_en), .clr(a_clr), .latch(a_latch),
        .cnt(a_cnt), .q(a_q), .ovr(a_ovr), .carry(a_carry), .ds(a_ds), .dq(a_dq)
    );

    mc_decade_counter #(.DIGITS(2), .MODE(1), .MSD_MAX(15), .SCAN_DIV(2)) dut_b (
        .cp(cp), .r(r), .en(b_en), .clr(b_clr), .latch(b_latch),
        .cnt(b_cnt), .q(b_q), .ovr(b_ovr), .carry(b_carry), .ds(b_ds), .dq(b_dq)
    );

    initial begin
        cp = 1'b0;
        forever #5 cp = ~cp;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic tick_a(input logic e, input logic c, input logic l);
        a_en = e; a_clr = c; a_latch = l;
        @(posedge cp); #1;
        a_en = 1'b0; a_clr = 1'b0; a_latch = 1'b0;
        if (a_carry) a_carry_seen = 1'b1;
    endtask

    task automatic tick_b(input logic e);
        b_en = e;
        @(posedge cp); #1;
        b_en = 1'b0;
        if (b_carry) b_carry_seen = 1'b1;
    endtask

    task automatic count_a(input int n);
        for (int i = 0; i < n; i++) tick_a(1'b1, 1'b0, 1'b0);
    endtask

    task automatic count_b(input int n);
        for (int i = 0; i < n; i++) tick_b(1'b1);
    endtask

    typedef struct {
        logic        en, clr, latch;
        logic [15:0] cnt, q;
        logic        ovr, carry;
    } vec_t;

    vec_t vt[6];

    initial begin
        logic [3:0] prev_ds;
        logic       synced;
        vt[0] = '{1'b1, 1'b0, 1'b0, 16'h0001, 16'h0000, 1'b0, 1'b0};
        vt[1] = '{1'b1, 1'b0, 1'b1, 16'h0002, 16'h0001, 1'b0, 1'b0};
        vt[2] = '{1'b0, 1'b0, 1'b0, 16'h0002, 16'h0001, 1'b0, 1'b0};
        vt[3] = '{1'b1, 1'b1, 1'b0, 16'h0000, 16'h0001, 1'b0, 1'b0};
        vt[4] = '{1'b1, 1'b0, 1'b1, 16'h0001, 16'h0000, 1'b0, 1'b0};
        vt[5] = '{1'b0, 1'b1, 1'b1, 16'h0000, 16'h0001, 1'b0, 1'b0};

        r = 1'b1;
        a_en = 0; a_clr = 0; a_latch = 0;
        b_en = 0; b_clr = 0; b_latch = 0;
        a_carry_seen = 0; b_carry_seen = 0;
        @(posedge cp); #1;
        r = 1'b0;
        chk("rst_cnt", 32'(a_cnt), 32'h0);
        chk("rst_q", 32'(a_q), 32'h0);
        chk("rst_ovr", 32'(a_ovr), 32'h0);
        chk("rst_carry", 32'(a_carry), 32'h0);
        chk("rst_ds", 32'(a_ds), 32'h8);
        chk("rst_b_ds", 32'(b_ds), 32'h2);

        // MSD held for 4 cycles after reset, then next digit.
        for (int i = 0; i < 3; i++) begin
            tick_a(1'b0, 1'b0, 1'b0);
            chk("rst_ds_hold", 32'(a_ds), 32'h8);
        end
        tick_a(1'b0, 1'b0, 1'b0);
        chk("rst_ds_step", 32'(a_ds), 32'h4);

        for (int i = 0; i < 6; i++) begin
            tick_a(vt[i].en, vt[i].clr, vt[i].latch);
            chk($sformatf("vec%0d_cnt", i), 32'(a_cnt), 32'(vt[i].cnt));
            chk($sformatf("vec%0d_q", i), 32'(a_q), 32'(vt[i].q));
            chk($sformatf("vec%0d_ovr", i), 32'(a_ovr), 32'(vt[i].ovr));
            chk($sformatf("vec%0d_carry", i), 32'(a_carry), 32'(vt[i].carry));
        end

        a_carry_seen = 0;
        count_a(10);
        chk("cnt_10", 32'(a_cnt), 32'h0010);
        count_a(90);
        chk("cnt_100", 32'(a_cnt), 32'h0100);
        chk("no_carry_100", 32'(a_carry_seen), 32'h0);
        chk("no_ovr_100", 32'(a_ovr), 32'h0);

        count_a(1899);
        chk("cnt_1999", 32'(a_cnt), 32'h1999);
        chk("no_carry_1999", 32'(a_carry_seen), 32'h0);
        tick_a(1'b1, 1'b0, 1'b0);
        chk("wrap_cnt", 32'(a_cnt), 32'h0);
        chk("wrap_carry", 32'(a_carry), 32'h1);
        chk("wrap_ovr", 32'(a_ovr), 32'h1);
        tick_a(1'b0, 1'b0, 1'b0);
        chk("wrap_carry_off", 32'(a_carry), 32'h0);
        chk("wrap_ovr_sticky", 32'(a_ovr), 32'h1);
        tick_a(1'b0, 1'b1, 1'b0);
        chk("clr_ovr", 32'(a_ovr), 32'h0);
        chk("clr_cnt", 32'(a_cnt), 32'h0);

        // clr beats en at full scale: no carry, no overrange.
        count_a(1999);
        tick_a(1'b1, 1'b1, 1'b0);
        chk("clr_wrap_cnt", 32'(a_cnt), 32'h0);
        chk("clr_wrap_carry", 32'(a_carry), 32'h0);
        chk("clr_wrap_ovr", 32'(a_ovr), 32'h0);

        count_a(457);
        chk("cnt_457", 32'(a_cnt), 32'h0457);
        tick_a(1'b1, 1'b0, 1'b1);
        chk("latch_en_q", 32'(a_q), 32'h0457);
        chk("latch_en_cnt", 32'(a_cnt), 32'h0458);
        tick_a(1'b0, 1'b1, 1'b1);
        chk("latch_clr_q", 32'(a_q), 32'h0458);
        chk("latch_clr_cnt", 32'(a_cnt), 32'h0);

        count_a(1234);
        tick_a(1'b0, 1'b0, 1'b1);
        chk("latch_1234", 32'(a_q), 32'h1234);

        // Align to the start of an MSD slot.
        synced = 1'b0;
        for (int i = 0; i < 40 && !synced; i++) begin
            prev_ds = a_ds;
            tick_a(1'b0, 1'b0, 1'b0);
            if (prev_ds == 4'b0001 && a_ds == 4'b1000) synced = 1'b1;
        end
        chk("scan_sync", 32'(synced), 32'h1);
        for (int d = 0; d < 4; d++) begin
            for (int c = 0; c < 4; c++) begin
                chk($sformatf("scan_ds_d%0d_c%0d", d, c), 32'(a_ds), 32'(4'b1000 >> d));
                chk($sformatf("scan_dq_d%0d_c%0d", d, c), 32'(a_dq), 32'(d + 1));
                tick_a(1'b0, 1'b0, 1'b0);
            end
        end
        chk("scan_return_msd", 32'(a_ds), 32'h8);

        // Overrange plus 730, then reset with en held high.
        tick_a(1'b0, 1'b1, 1'b0);
        count_a(2000);
        count_a(730);
        tick_a(1'b0, 1'b0, 1'b1);
        chk("pre_r_cnt", 32'(a_cnt), 32'h0730);
        chk("pre_r_ovr", 32'(a_ovr), 32'h1);
        tick_a(1'b0, 1'b0, 1'b0);
        r = 1'b1;
        tick_a(1'b1, 1'b0, 1'b0);
        r = 1'b0;
        chk("midr_cnt", 32'(a_cnt), 32'h0);
        chk("midr_q", 32'(a_q), 32'h0);
        chk("midr_ovr", 32'(a_ovr), 32'h0);
        chk("midr_ds", 32'(a_ds), 32'h8);

        // Binary 2-digit chain.
        count_b(15);
        chk("b_cnt_0f", 32'(b_cnt), 32'h0F);
        tick_b(1'b1);
        chk("b_cnt_10", 32'(b_cnt), 32'h10);
        count_b(239);
        chk("b_cnt_ff", 32'(b_cnt), 32'hFF);
        chk("b_no_carry", 32'(b_carry_seen), 32'h0);
        tick_b(1'b1);
        chk("b_wrap_cnt", 32'(b_cnt), 32'h00);
        chk("b_wrap_carry", 32'(b_carry), 32'h1);
        chk("b_wrap_ovr", 32'(b_ovr), 32'h1);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/mc_decade_counter.md
Name: mc_decade_counter

Overview:
- Parametrised synchronous digit-counter chain for the MC14433 digital back end.
- Replaces the fixed 4-bit ripple divider clocked from All_clock CP15 with a single-clock design.
- Counts on a qualified tick, supports BCD or binary digits with a limited most-significant ("half") digit, and flags overrange.
- Latches the count into a display register and scans it out one digit at a time with a one-hot digit strobe.

Parameters:
- DIGITS, 4, number of 4-bit digits in the chain (2..8).
- MODE, 0, digit radix: 0 = BCD (0..9 per digit), 1 = binary (0..15 per digit).
- MSD_MAX, 1, maximum value of the most significant digit; must be ≤ radix-1 (1 gives the MC14433 1999 full scale).
- SCAN_DIV, 4, cp cycles each digit stays selected during scan-out (≥1).

Ports:
- cp  input  1  clock; all state changes on rising edge.
- r  input  1  reset, synchronous, active-high.
- en  input  1  count tick (one-cycle strobe, e.g. divided CP15); increments when high.
- clr  input  1  synchronous clear of the live count and overrange flag.
- latch  input  1  transfer the live count to the display register.
- cnt  output  4*DIGITS  live count; digit k occupies bits [4k+3:4k]; digit 0 is LSD.
- q  output  4*DIGITS  latched display value.
- ovr  output  1  sticky overrange flag.
- carry  output  1  one-cycle pulse on full-scale wrap.
- ds  output  DIGITS  one-hot digit select for scan-out.
- dq  output  4  digit of q currently selected by ds.

Behaviour:
- Reset (r=1 at edge): cnt=0, q=0, ovr=0, carry=0, ds=one-hot MSD (bit DIGITS-1), scan divider=0. r overrides all other inputs.
- Priority below reset: clr > en for cnt/ovr. latch is independent of both.
- Increment (en=1, clr=0):
  - Digit 0 adds 1.
  - Digit k rolls to 0 and carries into k+1 when it is at its max (9 in BCD, 15 in binary) and all lower digits carry.
  - The MSD max is MSD_MAX, not radix-1.
  - Result is visible on cnt the cycle after the en edge.
- Full-scale wrap: en while every digit is at its max (e.g. 1999) gives cnt=0, carry=1 for exactly one cycle, and ovr=1.
- ovr stays set until clr or r. A further wrap keeps ovr=1 and pulses carry again.
- carry is 0 in all cycles without a wrap. clr forces carry=0 in its cycle's output.
- clr=1: cnt=0 and ovr=0 on the next edge, regardless of en.
- latch=1: q captures cnt as it is before this edge's update (pre-increment, pre-clear). latch with en/clr in the same cycle is legal. q is held otherwise.
- Digit values outside range never occur; no illegal-state recovery is required beyond reset.
- Scan-out:
  - Scan runs continuously. The divider counts 0..SCAN_DIV-1.
  - On terminal count, ds rotates one position toward the LSD. After the LSD it returns to the MSD.
  - Each digit is held for exactly SCAN_DIV cycles.
  - dq is combinational from q and ds, so a latch updates dq without waiting for the scan.
- Reset mid-count or mid-scan: all state returns to reset values on that edge and the next scan starts at the MSD.

Test Plan:
- DIGITS=4, MODE=0, MSD_MAX=1: reset, then 10 en pulses -> cnt=0x0010. A further 90 pulses -> cnt=0x0100. carry never high, ovr=0.
- Preload by counting to 1999 (0x1999), one more en -> cnt=0x0000, carry high for exactly 1 cycle, ovr=1. Then clr -> ovr=0, cnt=0x0000.
- MODE=1, DIGITS=2, MSD_MAX=15: count to 0x0F, en -> 0x10. Count to 0xFF, en -> 0x00 with carry and ovr=1.
- At cnt=0x0457, latch and en asserted in the same cycle -> q=0x0457, cnt=0x0458. latch and clr in the same cycle -> q=old cnt, cnt=0.
- With q=0x1234 and SCAN_DIV=4:
  - After reset, ds=4'b1000 and dq=1 for 4 cycles.
  - Then 4'b0100/dq=2, 4'b0010/dq=3, 4'b0001/dq=4.
  - Then back to 4'b1000.
- Assert r for one cycle mid-scan with cnt=0x0730 and ovr=1 -> the next cycle shows cnt=0, q=0, ovr=0, ds=4'b1000. en during r is ignored.
